// File: rtl/sonic_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranger.
//   state_t  : sequencing FSM states shared by all channels
//   MM_MUL / MM_SHIFT : echo-time (us) to millimetre scaling, mm = us*MM_MUL >> MM_SHIFT
package sonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEAS,
        DONE,
        HOLD
    } state_t;

    // 5650 / 2^15 ~= 1/5.8 mm per microsecond of round-trip echo
    localparam int MM_MUL   = 5650;
    localparam int MM_SHIFT = 15;

endpackage

// File: rtl/sonic_echo_sync.sv
// Echo input conditioning for one sensor channel.
//   clk, rst : system clock, synchronous active-high reset
//   echo     : raw asynchronous echo pin
//   rise     : one-clk pulse on a low-to-high transition of the synchronized echo
//   fall     : one-clk pulse on a high-to-low transition of the synchronized echo
module sonic_echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic rise,
    output logic fall
);

    // sh[0] may go metastable, sh[1] is the synchronized level, sh[2] its previous value
    logic [2:0] sh;

    always_ff @(posedge clk) begin
        if (rst) sh <= '0;
        else     sh <= {sh[1:0], echo};
    end

    assign rise =  sh[1] & ~sh[2];
    assign fall = ~sh[1] &  sh[2];

endmodule

// File: rtl/sonic_ranger_multi.sv
// Multi-channel HC-SR04 style ranger. One shared FSM fires each sensor in its own
// round-robin slot, times the echo in 1 us ticks, converts to mm and keeps a
// hysteretic near flag per channel; stop is the registered OR of all near flags.
//   clk, rst   : system clock, synchronous active-high reset
//   enable     : 1 = keep ranging; 0 = finish the current slot, then idle
//   echo       : raw asynchronous echo inputs, one per channel
//   trig       : registered trigger outputs
//   dist_flat  : last distance per channel in mm, ch0 in the LSBs
//   dist_valid : one-clk pulse when a channel result is published
//   dist_ch    : channel of the current dist_valid
//   timeout    : last measurement on that channel timed out
//   near       : per-channel hysteretic near flag
//   stop       : OR of near, registered
module sonic_ranger_multi
    import sonic_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int TICK_DIV   = 100,
    parameter  int TRIG_US    = 10,
    parameter  int SLOT_US    = 60000,
    parameter  int TIMEOUT_US = 30000,
    parameter  int DIST_W     = 16,
    parameter  int STOP_MM    = 400,
    parameter  int HYST_MM    = 50,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        echo,
    output logic [NUM_CH-1:0]        trig,
    output logic [NUM_CH*DIST_W-1:0] dist_flat,
    output logic                     dist_valid,
    output logic [CH_W-1:0]          dist_ch,
    output logic [NUM_CH-1:0]        timeout,
    output logic [NUM_CH-1:0]        near,
    output logic                     stop
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // slot counter must survive a late rise plus a full-length echo before HOLD
    localparam int SW = $clog2(SLOT_US + TRIG_US + 2*TIMEOUT_US + 2);
    localparam int EW = $clog2(TIMEOUT_US + 1);

    // ---------------- 1 us tick prescaler (free-running) ----------------
    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV-1));

    always_ff @(posedge clk) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + PW'(1);
    end

    // ---------------- echo synchronizers ----------------
    logic [NUM_CH-1:0] ech_rise, ech_fall;

    sonic_echo_sync u_sync [NUM_CH-1:0] (
        .clk  (clk),
        .rst  (rst),
        .echo (echo),
        .rise (ech_rise),
        .fall (ech_fall)
    );

    // ---------------- FSM state ----------------
    state_t          state;
    logic [CH_W-1:0] ch, ch_nxt;
    logic [SW-1:0]   slot_cnt;   // ticks since TRIG entry
    logic [EW-1:0]   echo_cnt;   // wait ticks in WAIT_RISE, echo ticks in MEAS
    logic            to_flag;
    logic            rise_pend;  // echo rose while the trigger was still high
    logic            ch_rise, ch_fall;

    assign ch_rise = ech_rise[ch];
    assign ch_fall = ech_fall[ch];
    assign ch_nxt  = (ch == CH_W'(NUM_CH-1)) ? '0 : ch + CH_W'(1);

    // ---------------- conversion ----------------
    logic [31:0]       prod, mm32;
    logic [DIST_W-1:0] mm;

    assign prod = 32'(echo_cnt) * 32'(MM_MUL);
    assign mm32 = prod >> MM_SHIFT;
    assign mm   = ((mm32 >> DIST_W) != 32'd0) ? '1 : mm32[DIST_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= '0;
            slot_cnt   <= '0;
            echo_cnt   <= '0;
            to_flag    <= 1'b0;
            rise_pend  <= 1'b0;
            trig       <= '0;
            dist_flat  <= '1;
            dist_valid <= 1'b0;
            dist_ch    <= '0;
            timeout    <= '0;
            near       <= '0;
            stop       <= 1'b0;
        end else begin
            dist_valid <= 1'b0;
            stop       <= |near;
            if (tick && state != IDLE) slot_cnt <= slot_cnt + SW'(1);

            case (state)
                IDLE: begin
                    if (enable && tick) begin
                        state     <= TRIG;
                        slot_cnt  <= '0;
                        echo_cnt  <= '0;
                        to_flag   <= 1'b0;
                        rise_pend <= 1'b0;
                        trig[ch]  <= 1'b1;
                    end
                end

                TRIG: begin
                    // A level already high at entry never produces ch_rise, so
                    // only a fresh transition arms the measurement here.
                    if (tick) echo_cnt <= echo_cnt + EW'(1);
                    if (ch_rise) begin
                        rise_pend <= 1'b1;
                        echo_cnt  <= '0;
                    end else if (ch_fall) begin
                        rise_pend <= 1'b0;
                    end
                    if (tick && slot_cnt == SW'(TRIG_US-1)) begin
                        trig <= '0;
                        if (ch_rise || (rise_pend && !ch_fall)) begin
                            state <= MEAS;
                        end else begin
                            state    <= WAIT_RISE;
                            echo_cnt <= '0;
                        end
                    end
                end

                WAIT_RISE: begin
                    if (ch_rise) begin
                        state    <= MEAS;
                        echo_cnt <= '0;
                    end else if (echo_cnt == EW'(TIMEOUT_US)) begin
                        state   <= DONE;
                        to_flag <= 1'b1;
                    end else if (tick) begin
                        echo_cnt <= echo_cnt + EW'(1);
                    end
                end

                MEAS: begin
                    // The tick on the fall-detect clk is still counted so that a
                    // pulse of N*TICK_DIV clks always yields exactly N.
                    if (echo_cnt == EW'(TIMEOUT_US)) begin
                        state   <= DONE;
                        to_flag <= 1'b1;
                    end else begin
                        if (tick)    echo_cnt <= echo_cnt + EW'(1);
                        if (ch_fall) state    <= DONE;
                    end
                end

                DONE: begin
                    dist_valid <= 1'b1;
                    dist_ch    <= ch;
                    if (to_flag) begin
                        dist_flat[int'(ch)*DIST_W +: DIST_W] <= '1;
                        timeout[ch] <= 1'b1;
                        near[ch]    <= 1'b0;
                    end else begin
                        dist_flat[int'(ch)*DIST_W +: DIST_W] <= mm;
                        timeout[ch] <= 1'b0;
                        if (mm32 < 32'(STOP_MM))                 near[ch] <= 1'b1;
                        else if (mm32 >= 32'(STOP_MM + HYST_MM)) near[ch] <= 1'b0;
                    end
                    state <= HOLD;
                end

                HOLD: begin
                    // >= covers a measurement that ran past the nominal slot end
                    if (tick && slot_cnt >= SW'(SLOT_US-1)) begin
                        ch        <= ch_nxt;
                        slot_cnt  <= '0;
                        echo_cnt  <= '0;
                        to_flag   <= 1'b0;
                        rise_pend <= 1'b0;
                        if (enable) begin
                            state        <= TRIG;
                            trig[ch_nxt] <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sonic_ranger_multi.sv
// Directed bench for sonic_ranger_multi with shortened timing
// (TICK_DIV=2, SLOT_US=3000, TIMEOUT_US=2800).
module tb_sonic_ranger_multi;

    localparam int NC   = 2;
    localparam int TD   = 2;
    localparam int TRG  = 10;
    localparam int SLOT = 3000;
    localparam int TO   = 2800;
    localparam int DW   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [NC-1:0]    echo;
    logic [NC-1:0]    trig;
    logic [NC*DW-1:0] dist_flat;
    logic             dist_valid;
    logic [0:0]       dist_ch;
    logic [NC-1:0]    timeout;
    logic [NC-1:0]    near;
    logic             stop;

    sonic_ranger_multi #(
        .NUM_CH(NC), .TICK_DIV(TD), .TRIG_US(TRG), .SLOT_US(SLOT), .TIMEOUT_US(TO),
        .DIST_W(DW), .STOP_MM(400), .HYST_MM(50)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
        .dist_flat(dist_flat), .dist_valid(dist_valid), .dist_ch(dist_ch),
        .timeout(timeout), .near(near), .stop(stop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int valid_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (dist_valid === 1'b1) valid_cnt++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_rst_state(input string tag);
        chk({tag, "_trig"},    trig,       '0);
        chk({tag, "_dist"},    dist_flat,  32'hFFFF_FFFF);
        chk({tag, "_valid"},   dist_valid, 0);
        chk({tag, "_ch"},      dist_ch,    0);
        chk({tag, "_timeout"}, timeout,    0);
        chk({tag, "_near"},    near,       0);
        chk({tag, "_stop"},    stop,       0);
    endtask

    // Waits for trig[c] to rise, returns the cycle stamp, checks the high width.
    task automatic wait_trig(input int c, output int t_rise);
        int n = 0;
        while (trig[c] !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
        chk("trig_seen", n < 20000, 1);
        t_rise = cyc;
        n = 0;
        while (trig[c] === 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("trig_width", n, TRG*TD);
    endtask

    task automatic wait_valid(input int lim);
        int n = 0;
        while (dist_valid !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        chk("valid_seen", dist_valid, 1);
    endtask

    // Echo pulse of 'ticks' us after 'pre' us; checks the 4-clk result latency.
    task automatic meas(input int c, input int ticks, input int pre);
        repeat (pre*TD) @(negedge clk);
        echo[c] = 1'b1;
        repeat (ticks*TD) @(negedge clk);
        echo[c] = 1'b0;
        repeat (3) @(negedge clk);
        chk("valid_early", dist_valid, 0);
        @(negedge clk);
        chk("valid_lat", dist_valid, 1);
    endtask

    task automatic chk_res(input int c, input logic [15:0] d, input logic to, input logic nr);
        chk("dist_ch", dist_ch, c);
        chk("dist",    dist_flat[c*DW +: DW], d);
        chk("timeout", timeout[c], to);
        chk("near",    near[c], nr);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t0, t1, t2, tt;
        int seen, vc0, bad;

        rst = 1'b1; enable = 1'b0; echo = '0;
        repeat (3) @(negedge clk);
        chk_rst_state("reset");
        rst = 1'b0; enable = 1'b1;

        // slot 0, ch0: 2320 us -> 400 mm, inside hysteresis band from near=0
        wait_trig(0, t0);
        meas(0, 2320, 5);
        chk_res(0, 16'd400, 0, 0);
        @(negedge clk); chk("stop_400", stop, 0);

        // slot 1, ch1: no echo -> timeout 2800 ticks after WAIT_RISE entry
        wait_trig(1, t1);
        chk("slot_0_to_1", t1 - t0, SLOT*TD);
        wait_valid(7000);
        chk("to_latency", cyc - t1, 5622);
        chk_res(1, 16'hFFFF, 1, 0);

        // slot 2, ch0 (wrap from ch1): 2300 us -> 396 mm, near sets, stop a clk later
        wait_trig(0, t2);
        chk("slot_1_to_0", t2 - t1, SLOT*TD);
        meas(0, 2300, 5);
        chk_res(0, 16'd396, 0, 1);
        chk("stop_pre", stop, 0);
        @(negedge clk); chk("stop_396", stop, 1);

        // slot 3, ch1: echo held past the timeout -> timeout result at echo_cnt limit
        wait_trig(1, tt);
        repeat (5*TD) @(negedge clk);
        echo[1] = 1'b1; seen = 0;
        for (int i = 0; i < 2900*TD; i++) begin
            @(negedge clk);
            if (dist_valid === 1'b1) begin seen++; chk_res(1, 16'hFFFF, 1, 0); end
        end
        echo[1] = 1'b0;
        chk("held_to_once", seen, 1);

        // slot 4, ch0: 2500 us -> 431 mm, near holds
        wait_trig(0, tt);
        meas(0, 2500, 5);
        chk_res(0, 16'd431, 0, 1);
        @(negedge clk); chk("stop_431", stop, 1);

        // slot 5, ch1: normal far result clears timeout[1]
        wait_trig(1, tt);
        meas(1, 2700, 5);
        chk_res(1, 16'd465, 0, 0);

        // slot 6, ch0: 2610 us -> 450 mm clears near; ch1 goes high meanwhile (ignored)
        wait_trig(0, tt);
        echo[1] = 1'b1;
        meas(0, 2610, 5);
        chk_res(0, 16'd450, 0, 0);
        chk("stop_hold", stop, 1);
        @(negedge clk); chk("stop_450", stop, 0);

        // slot 7, ch1: stale high at TRIG entry, then fall, real pulse of 580 us;
        // enable dropped mid-measurement
        wait_trig(1, tt);
        repeat (10*TD) @(negedge clk);
        echo[1] = 1'b0;
        repeat (100*TD) @(negedge clk);
        echo[1] = 1'b1;
        repeat (300*TD) @(negedge clk);
        enable = 1'b0;
        repeat (280*TD) @(negedge clk);
        echo[1] = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_early", dist_valid, 0);
        @(negedge clk);
        chk("stale_lat", dist_valid, 1);
        chk_res(1, 16'd100, 0, 1);
        @(negedge clk); chk("stop_100", stop, 1);

        // parked in IDLE: no trigger or result after the slot would have ended
        vc0 = valid_cnt; bad = 0;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (trig !== '0) bad++;
        end
        chk("idle_trig", bad, 0);
        chk("idle_valid", valid_cnt - vc0, 0);

        // resume on ch0, reset in the middle of MEAS
        enable = 1'b1;
        wait_trig(0, tt);
        repeat (5*TD) @(negedge clk);
        echo[0] = 1'b1;
        repeat (500*TD) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_rst_state("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vc0 = valid_cnt;
        echo[0] = 1'b0;
        repeat (200) @(negedge clk);
        chk("rst_no_valid", valid_cnt - vc0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
